// File: rtl/mem_noc_arb_rr_pkg.sv
// Shared memory-NoC configuration, payload types and arbiter state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).

package urv_cfg;
    // Outstanding requests the memory-NoC arbiter may track per slave port.
    localparam int MEM_NOC_MAX_OUTS = 4;
endpackage

package urv_typedef;
    // Request beat from a master towards a memory slave.
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

    // Response beat from a memory slave back to a master.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;
endpackage

package mem_noc_arb_rr_pkg;
    // IDLE: a fresh round-robin decision every cycle.
    // HOLD: an offered request was stalled by the slave; its grant is frozen.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;
endpackage

// File: rtl/mem_noc_id_fifo.sv
// Outstanding-ID FIFO: remembers which master owns each in-flight request.
// Latency: head valid the cycle after push into an empty FIFO; pop is combinational on head.
// Backpressure: push ignored when full, pop ignored when empty; callers check full/empty.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   push, push_dat write one ID at the tail
//   pop            drop the head entry
//   head           ID at the head (meaningful only when !empty)
//   full, empty    occupancy flags
//   cnt            current number of stored IDs

module mem_noc_id_fifo #(
    parameter  int W     = 2,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] cnt
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign cnt     = cnt_q;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap without compare logic.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_noc_arb_rr.sv
// Round-robin N:1 memory-NoC request arbiter with in-order response return to the requester.
// Latency: 0 cycles on both request and response paths (pure combinational steering).
// Backpressure: grant freezes while the slave stalls; no grant while MAX_OUTS are in flight;
//               responses stall while the owning master is not ready.
//
// Ports:
//   clk, rstn                               clock, asynchronous active-low reset
//   mn_req_valid/mn_req_ready/mn_req        per-master request channels
//   mn_resp_valid/mn_resp_ready/mn_resp     per-master response channels (payload broadcast)
//   sn_req_valid/sn_req_ready/sn_req        shared slave request channel
//   sn_resp_valid/sn_resp_ready/sn_resp     shared slave response channel (in-order)
//   outs_cnt                                requests accepted but not yet answered
//   busy                                    requests in flight or a stalled grant pending

module mem_noc_arb_rr
    import urv_typedef::*;
    import mem_noc_arb_rr_pkg::*;
#(
    parameter  int NUM_MN   = 4,
    parameter  int MAX_OUTS = urv_cfg::MEM_NOC_MAX_OUTS,
    localparam int ID_W     = $clog2(NUM_MN),
    localparam int CNT_W    = $clog2(MAX_OUTS) + 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MN-1:0]      mn_req_valid,
    output logic [NUM_MN-1:0]      mn_req_ready,
    input  mem_req_t [NUM_MN-1:0]  mn_req,
    output logic [NUM_MN-1:0]      mn_resp_valid,
    input  logic [NUM_MN-1:0]      mn_resp_ready,
    output mem_resp_t [NUM_MN-1:0] mn_resp,
    output logic                   sn_req_valid,
    input  logic                   sn_req_ready,
    output mem_req_t               sn_req,
    input  logic                   sn_resp_valid,
    output logic                   sn_resp_ready,
    input  mem_resp_t              sn_resp,
    output logic [CNT_W-1:0]       outs_cnt,
    output logic                   busy
);

    // First requester strictly after 'last', wrapping modulo NUM_MN.
    // With no requester the result is 'last'; callers gate on |req.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_MN-1:0] req,
                                                input logic [ID_W-1:0]   last);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] cand;
        logic            found;
        int              idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_MN; k++) begin
            idx  = (int'(last) + k) % NUM_MN;
            cand = ID_W'(idx);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] hid;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    assign win = rr_pick(mn_req_valid, last_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            // Start "after" the last master so master 0 wins the first round.
            last_q  <= ID_W'(NUM_MN - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        sel          = win;
        sn_req_valid = 1'b0;
        mn_req_ready = '0;
        push         = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // rstn gate keeps sn_req_valid low while reset is held even
                // if masters keep their valids up.
                if (rstn && !fifo_full && (|mn_req_valid)) begin
                    sn_req_valid      = 1'b1;
                    mn_req_ready[win] = sn_req_ready;
                    if (sn_req_ready) begin
                        push   = 1'b1;
                        last_d = win;
                    end else begin
                        gnt_d   = win;
                        state_d = ARB_HOLD;
                    end
                end
            end
            ARB_HOLD: begin
                // Frozen grant: later higher-priority valids cannot pre-empt a
                // request the slave has already seen. A FIFO slot was free on
                // entry and nothing else pushes meanwhile, so no full check.
                sel                 = gnt_q;
                sn_req_valid        = mn_req_valid[gnt_q];
                mn_req_ready[gnt_q] = sn_req_ready;
                if (mn_req_valid[gnt_q] && sn_req_ready) begin
                    push    = 1'b1;
                    last_d  = gnt_q;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign sn_req = sn_req_valid ? mn_req[sel] : '0;

    mem_noc_id_fifo #(
        .W     (ID_W),
        .DEPTH (MAX_OUTS)
    ) u_id_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .push_dat (sel),
        .pop      (pop),
        .head     (hid),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .cnt      (outs_cnt)
    );

    // An empty FIFO refuses every response, so an unsolicited beat stays
    // stalled at the slave instead of being routed to a stale master.
    assign sn_resp_ready = !fifo_empty && mn_resp_ready[hid];
    assign pop           = sn_resp_valid && sn_resp_ready;

    always_comb begin
        mn_resp_valid = '0;
        if (sn_resp_valid && !fifo_empty) begin
            mn_resp_valid[hid] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MN; i++) begin
            mn_resp[i] = sn_resp;
        end
    end

    assign busy = (outs_cnt != '0) || (state_q == ARB_HOLD);

endmodule

// File: tb/tb_mem_noc_arb_rr.sv
module tb_mem_noc_arb_rr;
    import urv_typedef::*;

    localparam int N  = 4;
    localparam int MO = 4;
    localparam int CW = 3;

    logic             clk  = 1'b0;
    logic             rstn = 1'b0;
    logic [N-1:0]     mn_req_valid;
    logic [N-1:0]     mn_req_ready;
    mem_req_t [N-1:0] mn_req;
    logic [N-1:0]     mn_resp_valid;
    logic [N-1:0]     mn_resp_ready;
    mem_resp_t [N-1:0] mn_resp;
    logic             sn_req_valid;
    logic             sn_req_ready;
    mem_req_t         sn_req;
    logic             sn_resp_valid;
    logic             sn_resp_ready;
    mem_resp_t        sn_resp;
    logic [CW-1:0]    outs_cnt;
    logic             busy;

    always #5 clk = ~clk;

    mem_noc_arb_rr #(.NUM_MN(N), .MAX_OUTS(MO)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .mn_req_valid  (mn_req_valid),
        .mn_req_ready  (mn_req_ready),
        .mn_req        (mn_req),
        .mn_resp_valid (mn_resp_valid),
        .mn_resp_ready (mn_resp_ready),
        .mn_resp       (mn_resp),
        .sn_req_valid  (sn_req_valid),
        .sn_req_ready  (sn_req_ready),
        .sn_req        (sn_req),
        .sn_resp_valid (sn_resp_valid),
        .sn_resp_ready (sn_resp_ready),
        .sn_resp       (sn_resp),
        .outs_cnt      (outs_cnt),
        .busy          (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int q[$];          // owners of in-flight requests, oldest first
    int last_g = N-1;  // most recently served master
    int locked = -1;   // master whose stalled request must be served next, -1 if none
    int acc_log[$];    // masters actually accepted by the DUT
    int resp_log[$];   // masters that actually received a response

    function automatic int rr_next(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Master whose request is presented to the slave this cycle, -1 for none.
    function automatic int offer();
        if (locked >= 0) return locked;
        if (q.size() >= MO) return -1;
        return rr_next(mn_req_valid, last_g);
    endfunction

    always @(negedge clk) begin
        int               w;
        logic             e_sv;
        logic             e_srr;
        logic [N-1:0]     e_rdy;
        logic [N-1:0]     e_rv;
        mem_resp_t [N-1:0] e_resp;
        e_sv  = 1'b0;
        e_srr = 1'b0;
        e_rdy = '0;
        e_rv  = '0;
        w     = -1;
        if (rstn) begin
            w = offer();
            if (w >= 0) begin
                e_sv     = mn_req_valid[w];
                e_rdy[w] = sn_req_ready;
            end
            if (q.size() > 0) begin
                e_srr       = mn_resp_ready[q[0]];
                e_rv[q[0]]  = sn_resp_valid;
            end
        end
        for (int i = 0; i < N; i++) e_resp[i] = sn_resp;
        check("sn_req_valid", sn_req_valid, e_sv);
        check("mn_req_ready", mn_req_ready, e_rdy);
        if (e_sv) check("sn_req", sn_req, mn_req[w]);
        check("sn_resp_ready", sn_resp_ready, e_srr);
        check("mn_resp_valid", mn_resp_valid, e_rv);
        check("mn_resp", mn_resp, e_resp);
        check("outs_cnt", outs_cnt, rstn ? q.size() : 0);
        check("busy", busy, rstn && (q.size() != 0 || locked >= 0));
    end

    always @(posedge clk) begin
        int w;
        int h;
        if (!rstn) begin
            q.delete();
            last_g = N-1;
            locked = -1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (mn_req_valid[i] && mn_req_ready[i]) acc_log.push_back(i);
                if (sn_resp_valid && sn_resp_ready && mn_resp_valid[i]) resp_log.push_back(i);
            end
            w = offer();
            h = (q.size() > 0) ? q[0] : -1;
            if (h >= 0 && sn_resp_valid && mn_resp_ready[h]) void'(q.pop_front());
            if (w >= 0 && mn_req_valid[w]) begin
                if (sn_req_ready) begin
                    q.push_back(w);
                    last_g = w;
                    locked = -1;
                end else begin
                    locked = w;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic mem_req_t req_pat(input int i);
        mem_req_t r;
        r.addr  = 32'h0000_1000 + 32'(i);
        r.we    = i[0];
        r.be    = 4'(1 << i);
        r.wdata = 32'hD000_0000 + 32'(i);
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Element i of the expected sequence sits in nibble i of seq.
    task automatic check_seq(input string name, input int which, input int n, input logic [31:0] seq);
        int sz;
        int a;
        sz = which ? resp_log.size() : acc_log.size();
        check({name, "_len"}, sz, n);
        for (int i = 0; i < n; i++) begin
            a = 15;
            if (i < sz) a = which ? resp_log[i] : acc_log[i];
            check(name, a, seq[4*i +: 4]);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) mn_req[i] = req_pat(i);
        sn_resp.rdata = 32'hCAFE_0001;
        sn_resp.err   = 1'b0;
        mn_req_valid  = '1;
        sn_req_ready  = 1'b1;
        sn_resp_valid = 1'b1;
        mn_resp_ready = '1;

        // Reset state with every input active
        #2;
        check("rst_sn_req_valid", sn_req_valid, 1'b0);
        check("rst_mn_req_ready", mn_req_ready, 4'b0000);
        check("rst_outs_cnt", outs_cnt, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_sn_resp_ready", sn_resp_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Rotation from reset, responses returned immediately
        tick(8);
        mn_req_valid = '0;
        tick(1);
        sn_resp_valid = 1'b0;
        check_seq("rot_grant", 0, 8, 32'h3210_3210);
        check_seq("rot_resp", 1, 8, 32'h3210_3210);
        check("rot_outs_cnt", outs_cnt, 3'd0);

        // Single request from master 2
        acc_log.delete();
        resp_log.delete();
        mn_req_valid = 4'b0100;
        @(negedge clk);
        check("single_ready", mn_req_ready, 4'b0100);
        check("single_sn_req", sn_req, req_pat(2));
        tick(1);
        mn_req_valid = '0;
        check("single_outs1", outs_cnt, 3'd1);
        sn_resp_valid = 1'b1;
        @(negedge clk);
        check("single_resp_valid", mn_resp_valid, 4'b0100);
        tick(1);
        sn_resp_valid = 1'b0;
        check("single_outs0", outs_cnt, 3'd0);

        // Backpressure hold on master 1 while master 0 also requests
        acc_log.delete();
        resp_log.delete();
        mn_req_valid = 4'b0010;
        sn_req_ready = 1'b0;
        tick(1);
        mn_req_valid = 4'b0011;
        @(negedge clk);
        check("hold_ready", mn_req_ready, 4'b0000);
        check("hold_sn_req", sn_req, req_pat(1));
        check("hold_busy", busy, 1'b1);
        tick(2);
        sn_req_ready = 1'b1;
        @(negedge clk);
        check("hold_release", mn_req_ready, 4'b0010);
        check("hold_sn_req2", sn_req, req_pat(1));
        tick(1);
        mn_req_valid = 4'b0001;
        @(negedge clk);
        check("hold_next", mn_req_ready, 4'b0001);
        tick(1);
        mn_req_valid = '0;
        check_seq("hold_grant", 0, 2, 32'h01);
        sn_resp_valid = 1'b1;
        tick(2);
        sn_resp_valid = 1'b0;
        check_seq("hold_resp", 1, 2, 32'h01);

        // FIFO full, pop in the same cycle still blocks the pending request
        acc_log.delete();
        resp_log.delete();
        mn_req_valid = '1;
        tick(4);
        check("full_outs", outs_cnt, 3'd4);
        @(negedge clk);
        check("full_ready", mn_req_ready, 4'b0000);
        check("full_sn_valid", sn_req_valid, 1'b0);
        check("full_busy", busy, 1'b1);
        tick(1);
        sn_resp_valid = 1'b1;
        @(negedge clk);
        check("full_pop_block", mn_req_ready, 4'b0000);
        check("full_pop_rdy", sn_resp_ready, 1'b1);
        tick(1);
        sn_resp_valid = 1'b0;
        @(negedge clk);
        check("full_after_pop", mn_req_ready, 4'b0010);
        tick(1);
        mn_req_valid = '0;
        check("full_outs2", outs_cnt, 3'd4);
        check_seq("full_grant", 0, 5, 32'h1_0321);

        // Response backpressure on master 3, then a spurious response
        resp_log.delete();
        sn_resp.rdata = 32'h1234_5678;
        sn_resp_valid = 1'b1;
        mn_resp_ready = 4'b0100;
        tick(1);
        mn_resp_ready = 4'b0111;
        @(negedge clk);
        check("rbp_sn_ready", sn_resp_ready, 1'b0);
        check("rbp_resp_valid", mn_resp_valid, 4'b1000);
        tick(1);
        check("rbp_outs", outs_cnt, 3'd3);
        mn_resp_ready = '1;
        tick(3);
        @(negedge clk);
        check("spur_sn_ready", sn_resp_ready, 1'b0);
        check("spur_resp_valid", mn_resp_valid, 4'b0000);
        check("spur_outs", outs_cnt, 3'd0);
        tick(1);
        sn_resp_valid = 1'b0;
        check_seq("rbp_resp", 1, 4, 32'h1032);

        // Reset while in HOLD with three outstanding
        mn_req_valid = '1;
        tick(3);
        sn_req_ready = 1'b0;
        tick(1);
        check("pre_rst_outs", outs_cnt, 3'd3);
        check("pre_rst_busy", busy, 1'b1);
        rstn = 1'b0;
        sn_resp_valid = 1'b1;
        #1;
        check("mid_rst_sn_valid", sn_req_valid, 1'b0);
        check("mid_rst_ready", mn_req_ready, 4'b0000);
        check("mid_rst_outs", outs_cnt, 3'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_resp_valid", mn_resp_valid, 4'b0000);
        check("mid_rst_sn_resp_ready", sn_resp_ready, 1'b0);
        tick(1);
        rstn = 1'b1;
        sn_req_ready  = 1'b1;
        sn_resp_valid = 1'b0;
        acc_log.delete();
        tick(2);
        mn_req_valid = '0;
        check_seq("post_rst_grant", 0, 2, 32'h10);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1);
    end

endmodule

// File: doc/mem_noc_arb_rr.md
# mem_noc_arb_rr

Round-robin N-to-1 request arbiter with in-order response routing for the memory NoC. It shares one slave port, such as the RAM or peripheral side of the memory NoC, between `NUM_MN` masters (fetch, load/store, debug, DMA). Accepted requests are tracked in an outstanding-ID FIFO, and responses are steered back to the originating master in acceptance order. The slave must return responses in order.

## Interface
- `NUM_MN`, default 4: number of masters; at least 2.
- `MAX_OUTS`, default 4: maximum outstanding requests; a power of 2, at least 2.
- `ID_W`, derived, `$clog2(NUM_MN)`: width of a master index.
- `CNT_W`, derived, `$clog2(MAX_OUTS)+1`: width of the outstanding count.

- `clk`  in  1  single clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `mn_req_valid`  in  NUM_MN  per-master request valid.
- `mn_req_ready`  out  NUM_MN  per-master request ready.
- `mn_req`  in  mem_req_t[NUM_MN]  per-master request payload.
- `mn_resp_valid`  out  NUM_MN  per-master response valid.
- `mn_resp_ready`  in  NUM_MN  per-master response ready.
- `mn_resp`  out  mem_resp_t[NUM_MN]  response payload; `sn_resp` is broadcast to all masters.
- `sn_req_valid`, `sn_req_ready`, `sn_req`  out/in/out  1/1/mem_req_t  slave request channel.
- `sn_resp_valid`, `sn_resp_ready`, `sn_resp`  in/out/in  1/1/mem_resp_t  slave response channel.
- `outs_cnt`  out  CNT_W  number of requests accepted but not yet responded.
- `busy`  out  1  high when `outs_cnt != 0` or the arbiter is in HOLD.

## Operation
- **Handshake.** A transfer occurs when valid and ready are both high on a rising edge of `clk`. Masters hold valid and payload stable until ready is seen.
- **Arbitration state machine.**
  - **IDLE.**
    - If `fifo_full`, no grant is made and all `mn_req_ready` are 0.
    - Otherwise the winner is the first requesting master searching upward from `last_grant+1` modulo `NUM_MN`.
    - `sn_req_valid` is 1, `sn_req = mn_req[win]`, and `mn_req_ready[win] = sn_req_ready`; all other readies are 0.
    - On accept: push `win` into the FIFO, set `last_grant <= win`, stay in IDLE.
    - If `sn_req_ready` is 0: latch `gnt <= win` and go to HOLD.
  - **HOLD.**
    - The grant stays frozen on `gnt`, even if a higher-priority master raises valid.
    - `sn_req_valid = mn_req_valid[gnt]`.
    - On accept: push `gnt`, set `last_grant <= gnt`, go to IDLE.
    - HOLD is entered only with a free FIFO slot, so a full FIFO never occurs in HOLD.
- **Response routing.** Responses leave in order of the FIFO head `hid`.
  - `sn_resp_ready = !fifo_empty & mn_resp_ready[hid]`.
  - `mn_resp_valid[hid] = sn_resp_valid & !fifo_empty`; all others are 0.
  - Pop on a slave response handshake.
  - FIFO empty: `sn_resp_ready = 0`, so a spurious response is never consumed.
- **Counters.**
  - `outs_cnt` increments on push, decrements on pop, and is unchanged when both happen in the same cycle.
  - Pointers are `$clog2(MAX_OUTS)` bits wide and wrap naturally.
  - Full when `outs_cnt == MAX_OUTS`. A push is blocked when full even if a pop occurs in the same cycle.
- **Reset.**
  - All ready and valid outputs are 0, `outs_cnt` is 0, `busy` is 0, state is IDLE.
  - `last_grant` resets to `NUM_MN-1`, so master 0 has first priority.
  - Reset mid-transaction discards all outstanding IDs; the slave must be reset together with this block.

## Timing
- Request and response paths are combinational, adding 0 cycles of latency.
- `mn_req_ready` depends combinationally on `sn_req_ready`; no other combinational loops exist.
- Maximum throughput is one request and one response per cycle, simultaneously.
- Fairness: under continuous requests, each master waits at most `NUM_MN-1` grants.
- Registered state: `state`, `gnt`, `last_grant`, FIFO storage and pointers, `outs_cnt`.

## Structure
- `mem_req_t` and `mem_resp_t` come from `urv_typedef`.
- Add `MEM_NOC_MAX_OUTS` to `urv_cfg`.
- The state enum (IDLE/HOLD) is local to the block.
- Sub-module `mem_noc_id_fifo` holds the outstanding-ID FIFO, parameterised by width and depth, with `push`, `pop`, `head`, `full`, `empty`, `cnt`.
- The round-robin priority search is a function inside the block.

## Test plan
- **Single request.** Master 2 requests alone with `sn_req_ready=1` → accepted the same cycle, `outs_cnt=1`. Response with `sn_resp_valid=1` → `mn_resp_valid=4'b0100`, `outs_cnt=0`.
- **Rotation.** All 4 masters request continuously with the slave always ready → grant sequence 0,1,2,3,0,1,…; responses return to masters in that order.
- **Backpressure hold.** Master 1 is granted and `sn_req_ready=0` for 3 cycles while master 0 also requests → grant stays on 1 and `sn_req` is unchanged; master 1 is accepted on cycle 4, master 0 next.
- **FIFO full.** With `MAX_OUTS=4`, issue 4 accepts with no response → all `mn_req_ready=0` and `busy=1`. A pop in the same cycle as a pending request still blocks it; the request is accepted the following cycle.
- **Response backpressure and spurious response.** Head is master 3 with `mn_resp_ready[3]=0` → `sn_resp_ready=0` and no pop. With the FIFO empty and `sn_resp_valid=1` → `sn_resp_ready=0` and no `mn_resp_valid`.
- **Reset mid-operation.** Assert `rstn=0` with 3 outstanding and the arbiter in HOLD → same cycle, all outputs 0 and `outs_cnt=0`. After release, master 0 has first priority.
